// File: rtl/idex_hazard_ctrl.sv
// ID/EX boundary sequencing controller.
// Handles load-use stalls, multi-cycle EX holds and taken-branch flushes.
// Also keeps a saturating count of cycles in which the PC was frozen.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal flow; branch > multi-cycle start > load-use hazard
// ST_MC    | multi-cycle EX op in progress; pipeline held, inputs ignored
// ST_FLUSH | extra flush cycles after a taken branch, inputs ignored
module idex_hazard_ctrl #(
    parameter int MC_LATENCY   = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_uses_rs1,
    input  logic             IFID_uses_rs2,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_MemoryRead,
    input  logic             ex_branch_taken,
    input  logic             mc_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             mc_busy,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MC_W = $clog2(MC_LATENCY + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MC    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hz;

    // Load-use hazard: EX holds a load whose destination (not x0) is read in ID.
    assign hz = IDEX_MemoryRead && (IDEX_rd != 5'd0) &&
                ((IFID_uses_rs1 && (IFID_rs1 == IDEX_rd)) ||
                 (IFID_uses_rs2 && (IFID_rs2 == IDEX_rd)));

    assign stall_cnt = stall_cnt_q;

    // Next-state and Mealy output decode; reset forces the safe output pattern.
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        mc_busy     = 1'b0;
        mc_done     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d  = ST_FLUSH;
                        fl_cnt_d = FL_W'(FLUSH_CYCLES - 1);
                    end
                end else if (mc_start) begin
                    idex_hold = 1'b1;
                    mc_busy   = 1'b1;
                    if (MC_LATENCY > 1) begin
                        state_d  = ST_MC;
                        mc_cnt_d = MC_W'(MC_LATENCY - 1);
                    end else begin
                        mc_done = 1'b1;
                    end
                end else if (hz) begin
                    idex_bubble = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end
            ST_MC: begin
                idex_hold = 1'b1;
                mc_busy   = 1'b1;
                if (mc_cnt_q <= MC_W'(1)) begin
                    mc_done = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    mc_cnt_d = mc_cnt_q - MC_W'(1);
                end
            end
            ST_FLUSH: begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (fl_cnt_q <= FL_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    fl_cnt_d = fl_cnt_q - FL_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            state_d     = ST_RUN;
            mc_cnt_d    = '0;
            fl_cnt_d    = '0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            idex_hold   = 1'b0;
            mc_busy     = 1'b0;
            mc_done     = 1'b0;
        end
    end

    // State and down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            mc_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    // Saturating count of frozen-PC cycles; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule
